// File: rtl/toggle_checker.sv
// toggle_checker: consumer of a single-bit toggle stream on the same clock.
// Emits rise/fall pulses, counts edges, checks edge spacing and reports
// LOCKED (steady good toggling) or STUCK (no edge within TIMEOUT cycles).
// Optional feature macro: TOGGLE_CHK_ERRCNT_EN adds the err_count output,
// counting bad edges and STUCK entries (saturating).
module toggle_checker #(
    parameter int CNT_W      = 16,
    parameter int EXPECT_GAP = 1,
    parameter int LOCK_N     = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in,
    input  logic             clear,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_count,
`ifdef TOGGLE_CHK_ERRCNT_EN
    output logic [CNT_W-1:0] err_count,
`endif
    output logic             locked,
    output logic             stuck
);

    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic [GAP_W-1:0] GOOD_GAP  = GAP_W'(EXPECT_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(LOCK_N);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        STUCK  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic               in_q, in_d;
    logic               edge_det;
    logic [GAP_W-1:0]   gap_cnt;
    logic [RUN_W-1:0]   good_run, run_nx, run_inc;
    logic               seen, seen_nx;
    logic               good_e, bad_e, to_stuck, timeout_hit;

    assign edge_det = in_q ^ in_d;
    assign locked   = (state == LOCKED);
    assign stuck    = (state == STUCK);

    // Two-stage sampler; keeps running through clear so history is never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_q <= 1'b0;
            in_d <= 1'b0;
        end else begin
            in_q <= in;
            in_d <= in_q;
        end
    end

    // Edge classification and FSM next-state; clear overrides everything.
    always_comb begin
        state_nx    = state;
        run_nx      = good_run;
        seen_nx     = seen;
        good_e      = 1'b0;
        bad_e       = 1'b0;
        to_stuck    = 1'b0;
        run_inc     = (good_run == RUN_MAX) ? good_run : good_run + 1'b1;
        // gap_cnt would hit TIMEOUT this cycle (it never sits at TIMEOUT outside STUCK)
        timeout_hit = !edge_det && (gap_cnt >= GAP_LAST);

        if (edge_det && seen && state != STUCK) begin
            good_e = (gap_cnt == GOOD_GAP);
            bad_e  = !good_e;
        end

        case (state)
            SEARCH, LOCKED: begin
                if (edge_det) begin
                    if (!seen) begin
                        seen_nx = 1'b1;           // reference edge only
                    end else if (good_e) begin
                        run_nx = run_inc;
                        if (run_inc == RUN_MAX) state_nx = LOCKED;
                    end else begin
                        run_nx   = '0;
                        state_nx = SEARCH;
                    end
                end else if (timeout_hit) begin
                    state_nx = STUCK;
                    seen_nx  = 1'b0;
                    run_nx   = '0;
                    to_stuck = 1'b1;
                end
            end
            STUCK: begin
                if (edge_det) begin
                    state_nx = SEARCH;
                    seen_nx  = 1'b1;              // this edge is the new reference
                    run_nx   = '0;
                end
            end
            default: begin
                state_nx = SEARCH;
                seen_nx  = 1'b0;
                run_nx   = '0;
            end
        endcase

        if (clear) begin
            state_nx = SEARCH;
            seen_nx  = 1'b0;
            run_nx   = '0;
            good_e   = 1'b0;
            bad_e    = 1'b0;
            to_stuck = 1'b0;
        end
    end

    // FSM and classification state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= SEARCH;
            good_run <= '0;
            seen     <= 1'b0;
        end else begin
            state    <= state_nx;
            good_run <= run_nx;
            seen     <= seen_nx;
        end
    end

    // Registered pulses, edge counter (wrapping) and gap counter (saturating).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rise       <= 1'b0;
            fall       <= 1'b0;
            edge_count <= '0;
            gap_cnt    <= '0;
        end else if (clear) begin
            rise       <= 1'b0;
            fall       <= 1'b0;
            edge_count <= '0;
            gap_cnt    <= '0;
        end else begin
            rise <= edge_det & in_q;
            fall <= edge_det & ~in_q;
            if (edge_det) edge_count <= edge_count + 1'b1;
            if (edge_det)                gap_cnt <= '0;
            else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
        end
    end

`ifdef TOGGLE_CHK_ERRCNT_EN
    // Saturating error counter: bad edges plus STUCK entries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if ((bad_e || to_stuck) && err_count != {CNT_W{1'b1}}) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
